// File: rtl/bsr_meta_buffer_if.sv
// Load-stream and metadata-read signal bundle for bsr_meta_buffer.
// master = DMA/scheduler side, slave = the buffer.
interface bsr_meta_buffer_if #(
    parameter int K_W   = 12,
    parameter int NNZ_W = 16
);
    logic             ld_start;
    logic [K_W-1:0]   ld_kt;
    logic [NNZ_W-1:0] ld_nnz;
    logic             ld_valid;
    logic             ld_ready;
    logic [31:0]      ld_data;
    logic             ld_done;
    logic             ld_err;
    logic             meta_loaded;
    logic             meta_ren;
    logic [31:0]      meta_raddr;
    logic             meta_req_ready;
    logic [31:0]      meta_rdata;
    logic             meta_rvalid;
    logic             meta_ready;
    logic             rd_err;

    modport master (
        output ld_start, ld_kt, ld_nnz, ld_valid, ld_data,
               meta_ren, meta_raddr, meta_ready,
        input  ld_ready, ld_done, ld_err, meta_loaded,
               meta_req_ready, meta_rdata, meta_rvalid, rd_err
    );

    modport slave (
        input  ld_start, ld_kt, ld_nnz, ld_valid, ld_data,
               meta_ren, meta_raddr, meta_ready,
        output ld_ready, ld_done, ld_err, meta_loaded,
               meta_req_ready, meta_rdata, meta_rvalid, rd_err
    );
endinterface

// File: rtl/bsr_meta_buffer.sv
// BSR metadata store: validated row_ptr/col_idx load from DMA, then
// single-word reads served through a 2-entry response FIFO.
module bsr_meta_buffer #(
    parameter int DEPTH        = 512,
    parameter int COL_IDX_BASE = 256,
    parameter int K_W          = 12,
    parameter int NNZ_W        = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    bsr_meta_buffer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (K_W > NNZ_W) ? K_W : NNZ_W;

    typedef enum logic [2:0] {L_IDLE, L_PTR, L_COL, L_DONE, L_ERR} lstate_e;

    lstate_e          state_q, state_d;
    logic [K_W-1:0]   kt_q;
    logic [NNZ_W-1:0] nnz_q;
    logic [CW-1:0]    cnt_q;
    logic [31:0]      prev_q;
    logic             ld_done_q;

    logic             start_acc, beat, cfg_bad, ptr_bad, ptr_last, col_last, ld_rdy;
    logic [AW-1:0]    waddr;

    logic [31:0]      mem [DEPTH];
    logic [31:0]      rd_q;
    logic             rd_vld_q, rd_oob_q, rd_err_q;
    logic             loaded, req_rdy, req_acc, req_oob;

    logic [1:0][31:0] f_mem_q;
    logic [1:0]       f_cnt_q;
    logic             f_wp_q, f_rp_q;
    logic             push, pop;
    logic [31:0]      push_data;

    // ---------------- load FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= L_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        ld_rdy    = (state_q == L_PTR) || (state_q == L_COL);
        start_acc = bus.ld_start && (state_q inside {L_IDLE, L_DONE, L_ERR});
        beat      = bus.ld_valid && ld_rdy;
        cfg_bad   = (32'(bus.ld_kt) + 32'd1 > 32'(COL_IDX_BASE)) ||
                    (32'(COL_IDX_BASE) + 32'(bus.ld_nnz) > 32'(DEPTH));
        ptr_last  = (CW'(kt_q) == cnt_q);
        col_last  = (CW'(nnz_q) == cnt_q + CW'(1));
        // row_ptr must start at 0, never decrease, and end at NNZ
        ptr_bad   = ((cnt_q == '0) && (bus.ld_data != 32'd0)) ||
                    ((cnt_q != '0) && (bus.ld_data < prev_q)) ||
                    (ptr_last && (bus.ld_data != 32'(nnz_q)));
        waddr     = (state_q == L_COL) ? AW'(COL_IDX_BASE) + AW'(cnt_q) : AW'(cnt_q);
        state_d   = state_q;
        case (state_q)
            L_IDLE, L_DONE, L_ERR:
                if (start_acc) state_d = cfg_bad ? L_ERR : L_PTR;
            L_PTR:
                if (beat) begin
                    if (ptr_bad)       state_d = L_ERR;
                    else if (ptr_last) state_d = (nnz_q == '0) ? L_DONE : L_COL;
                end
            L_COL:
                if (beat && col_last) state_d = L_DONE;
            default: state_d = L_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kt_q      <= '0;
            nnz_q     <= '0;
            cnt_q     <= '0;
            prev_q    <= '0;
            ld_done_q <= 1'b0;
        end else begin
            ld_done_q <= (state_d == L_DONE) && (state_q != L_DONE);
            if (start_acc) begin
                kt_q   <= bus.ld_kt;
                nnz_q  <= bus.ld_nnz;
                cnt_q  <= '0;
                prev_q <= '0;
            end else if (beat) begin
                prev_q <= bus.ld_data;
                cnt_q  <= ((state_q == L_PTR) && ptr_last) ? '0 : cnt_q + CW'(1);
            end
        end
    end

    assign bus.ld_ready    = ld_rdy;
    assign bus.ld_done     = ld_done_q;
    assign bus.ld_err      = (state_q == L_ERR);
    assign bus.meta_loaded = loaded;

    // ---------------- storage (BRAM, no reset) ----------------
    always_ff @(posedge clk) begin
        if (beat)    mem[waddr] <= bus.ld_data;
        if (req_acc) rd_q       <= mem[bus.meta_raddr[AW-1:0]];
    end

    // ---------------- read path ----------------
    // Credits cover both the BRAM stage and the FIFO, so a push never overflows.
    assign loaded  = (state_q == L_DONE);
    assign req_rdy = loaded && (({1'b0, f_cnt_q} + {2'b00, rd_vld_q}) < 3'd2);
    assign req_acc = bus.meta_ren && req_rdy;
    assign req_oob = (bus.meta_raddr >= 32'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= 1'b0;
            rd_oob_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            rd_vld_q <= req_acc;
            if (req_acc) rd_oob_q <= req_oob;
            if ((bus.meta_ren && !loaded) || (req_acc && req_oob)) rd_err_q <= 1'b1;
            else if (start_acc)                                    rd_err_q <= 1'b0;
        end
    end

    assign push      = rd_vld_q;
    assign push_data = rd_oob_q ? 32'd0 : rd_q;
    assign pop       = (f_cnt_q != 2'd0) && bus.meta_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_mem_q <= '0;
            f_wp_q  <= 1'b0;
            f_rp_q  <= 1'b0;
            f_cnt_q <= 2'd0;
        end else begin
            if (push) begin
                f_mem_q[f_wp_q] <= push_data;
                f_wp_q          <= ~f_wp_q;
            end
            if (pop) f_rp_q <= ~f_rp_q;
            case ({push, pop})
                2'b10:   f_cnt_q <= f_cnt_q + 2'd1;
                2'b01:   f_cnt_q <= f_cnt_q - 2'd1;
                default: f_cnt_q <= f_cnt_q;
            endcase
        end
    end

    assign bus.meta_req_ready = req_rdy;
    assign bus.meta_rvalid    = (f_cnt_q != 2'd0);
    assign bus.meta_rdata     = f_mem_q[f_rp_q];
    assign bus.rd_err         = rd_err_q;
endmodule
